// File: rtl/int_sched_ctrl_if.sv
// Handshake between the interrupt scheduler and control_unit.
// The master side is the scheduler: it raises the request and vector.
// The slave side is control_unit: it supplies the boundary, ack and RETI pulses.
interface int_sched_ctrl_if;
  logic       boundary;
  logic       reti_done;
  logic       int_ack;
  logic       int_req;
  logic [7:0] int_vector;
  logic [2:0] int_src;

  modport master (
    input  boundary,
    input  reti_done,
    input  int_ack,
    output int_req,
    output int_vector,
    output int_src
  );

  modport slave (
    output boundary,
    output reti_done,
    output int_ack,
    input  int_req,
    input  int_vector,
    input  int_src
  );
endinterface

// File: rtl/int_sched_ctrl.sv
// 8051-style interrupt scheduler.
// Latches request sources and applies the IE/IP enable and priority rules.
// Tracks two-level in-service nesting.
// At instruction boundaries it issues a held request and vector to control_unit.
module int_sched_ctrl #(
  parameter int unsigned          NSRC       = 5,
  parameter logic [7:0]           VEC_BASE   = 8'h03,
  parameter logic [7:0]           VEC_STRIDE = 8'h08,
  parameter logic [NSRC-1:0]      AUTO_CLR   = 5'b01111
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NSRC-1:0]         src_req,
  input  logic [NSRC-1:0]         sw_clr,
  input  logic [7:0]              ie,
  input  logic [NSRC-1:0]         ip,
  int_sched_ctrl_if.master        cu,
  output logic [NSRC-1:0]         pending,
  output logic                    in_svc_hi,
  output logic                    in_svc_lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01
  } state_t;

  state_t          state, state_nxt;
  logic            req_q, req_nxt;
  logic [2:0]      src_q, src_nxt;
  logic [7:0]      vec_q, vec_nxt;
  logic            grant_hi, grant_hi_nxt;
  logic            skip_next, skip_nxt;
  logic            svc_hi_nxt, svc_lo_nxt;
  logic [NSRC-1:0] pending_nxt;
  logic [NSRC-1:0] ack_clr;
  logic            take_ack;

  logic [NSRC-1:0] eligible, hi_elig;
  logic            sel_valid, sel_hi, blocked;
  logic [2:0]      sel_idx;
  logic [7:0]      sel_vec;

  assign cu.int_req    = req_q;
  assign cu.int_src    = src_q;
  assign cu.int_vector = vec_q;

  // Source selection from registered pending flags: high-priority group first, lowest index wins.
  always_comb begin
    eligible  = pending & ie[NSRC-1:0] & {NSRC{ie[7]}};
    hi_elig   = eligible & ip;
    sel_valid = |eligible;
    sel_hi    = |hi_elig;
    sel_idx   = '0;
    // Scan from the top down so the lowest matching index is the last one written.
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (sel_hi ? hi_elig[i-1] : eligible[i-1]) begin
        sel_idx = 3'(i - 1);
      end
    end
    sel_vec = VEC_BASE + 8'(sel_idx) * VEC_STRIDE;
    blocked = in_svc_hi | (in_svc_lo & ~sel_hi) | skip_next;
  end

  // Request FSM next-state: grant at an unblocked boundary, hold the request until acked.
  always_comb begin
    state_nxt    = state;
    req_nxt      = req_q;
    src_nxt      = src_q;
    vec_nxt      = vec_q;
    grant_hi_nxt = grant_hi;
    take_ack     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cu.boundary && sel_valid && !blocked) begin
          state_nxt    = S_REQ;
          req_nxt      = 1'b1;
          src_nxt      = sel_idx;
          vec_nxt      = sel_vec;
          grant_hi_nxt = sel_hi;
        end
      end
      S_REQ: begin
        if (cu.int_ack) begin
          state_nxt = S_IDLE;
          req_nxt   = 1'b0;
          take_ack  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // Nesting, skip and pending next values; a RETI clear is applied before an ack set in the same cycle.
  always_comb begin
    svc_hi_nxt = in_svc_hi;
    svc_lo_nxt = in_svc_lo;
    if (cu.reti_done) begin
      if (in_svc_hi) svc_hi_nxt = 1'b0;
      else           svc_lo_nxt = 1'b0;
    end
    if (take_ack) begin
      if (grant_hi) svc_hi_nxt = 1'b1;
      else          svc_lo_nxt = 1'b1;
    end

    skip_nxt = skip_next;
    if (state == S_IDLE && cu.boundary) skip_nxt = 1'b0;
    if (cu.reti_done)                   skip_nxt = 1'b1;

    for (int unsigned i = 0; i < NSRC; i++) begin
      ack_clr[i] = take_ack & (src_q == 3'(i)) & AUTO_CLR[i];
    end
    pending_nxt = src_req | (pending & ~sw_clr & ~ack_clr);
  end

  // State register with asynchronous reset; reset discards any outstanding request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      src_q     <= '0;
      vec_q     <= '0;
      grant_hi  <= 1'b0;
      skip_next <= 1'b0;
      in_svc_hi <= 1'b0;
      in_svc_lo <= 1'b0;
      pending   <= '0;
    end else begin
      state     <= state_nxt;
      req_q     <= req_nxt;
      src_q     <= src_nxt;
      vec_q     <= vec_nxt;
      grant_hi  <= grant_hi_nxt;
      skip_next <= skip_nxt;
      in_svc_hi <= svc_hi_nxt;
      in_svc_lo <= svc_lo_nxt;
      pending   <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_int_sched_ctrl.sv
// Self-checking bench for int_sched_ctrl.
// Expected grants go into a scoreboard queue when a boundary is driven.
// A negedge monitor pops and checks them when int_req rises.
module tb_int_sched_ctrl;

  typedef struct {
    logic [2:0] src;
    logic [7:0] vec;
  } grant_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] src_req;
  logic [4:0] sw_clr;
  logic [7:0] ie;
  logic [4:0] ip;
  logic [4:0] pending;
  logic       in_svc_hi;
  logic       in_svc_lo;

  int unsigned total = 0;
  int unsigned bad   = 0;
  grant_t      sb[$];
  logic        prev_req = 1'b0;

  int_sched_ctrl_if cu_if ();

  int_sched_ctrl #(
    .NSRC      (5),
    .VEC_BASE  (8'h03),
    .VEC_STRIDE(8'h08),
    .AUTO_CLR  (5'b01111)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .src_req  (src_req),
    .sw_clr   (sw_clr),
    .ie       (ie),
    .ip       (ip),
    .cu       (cu_if.master),
    .pending  (pending),
    .in_svc_hi(in_svc_hi),
    .in_svc_lo(in_svc_lo)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every rising int_req must match the oldest expected grant.
  always @(negedge clock) begin
    grant_t exp_g;
    if (cu_if.int_req === 1'b1 && prev_req !== 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_grant: got src=%0d vec=%h, required no request",
                 cu_if.int_src, cu_if.int_vector);
      end else begin
        exp_g = sb.pop_front();
        if (cu_if.int_src !== exp_g.src || cu_if.int_vector !== exp_g.vec) begin
          bad++;
          $display("FAIL grant_match: got src=%0d vec=%h, required src=%0d vec=%h",
                   cu_if.int_src, cu_if.int_vector, exp_g.src, exp_g.vec);
        end
      end
    end
    prev_req = cu_if.int_req;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_src(input logic [4:0] m);
    src_req = m;
    tick();
    src_req = '0;
  endtask

  task automatic pulse_boundary();
    cu_if.boundary = 1'b1;
    tick();
    cu_if.boundary = 1'b0;
  endtask

  task automatic pulse_ack();
    cu_if.int_ack = 1'b1;
    tick();
    cu_if.int_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    cu_if.reti_done = 1'b1;
    tick();
    cu_if.reti_done = 1'b0;
  endtask

  task automatic push_grant(input logic [2:0] s, input logic [7:0] v);
    grant_t g;
    g.src = s;
    g.vec = v;
    sb.push_back(g);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if (cu_if.int_req !== 1'b0 || cu_if.int_vector !== 8'h00 || cu_if.int_src !== 3'd0) begin
      bad++;
      $display("FAIL reset_req: got req=%b vec=%h src=%0d, required 0/00/0",
               cu_if.int_req, cu_if.int_vector, cu_if.int_src);
    end
    total++;
    if (pending !== 5'b0 || in_svc_hi !== 1'b0 || in_svc_lo !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got pend=%b hi=%b lo=%b, required 0/0/0",
               pending, in_svc_hi, in_svc_lo);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_grant();
    ie = 8'h81;
    ip = '0;
    pulse_src(5'b00001);
    pulse_ack();  // ack while idle must be ignored
    total++;
    if (pending !== 5'b00001 || in_svc_lo !== 1'b0) begin
      bad++;
      $display("FAIL idle_ack: got pend=%b lo=%b, required 00001/0", pending, in_svc_lo);
    end
    push_grant(3'd0, 8'h03);
    pulse_boundary();
    total++;
    if (cu_if.int_req !== 1'b1) begin
      bad++;
      $display("FAIL basic_req: got %b, required 1", cu_if.int_req);
    end
    pulse_ack();
    total++;
    if (cu_if.int_req !== 1'b0 || pending !== 5'b00000 || in_svc_lo !== 1'b1 || in_svc_hi !== 1'b0) begin
      bad++;
      $display("FAIL basic_ack: got req=%b pend=%b hi=%b lo=%b, required 0/00000/0/1",
               cu_if.int_req, pending, in_svc_hi, in_svc_lo);
    end
    pulse_reti();
    total++;
    if (in_svc_lo !== 1'b0) begin
      bad++;
      $display("FAIL basic_reti: got lo=%b, required 0", in_svc_lo);
    end
    pulse_boundary();
  endtask

  task automatic test_priority_skip();
    ie = 8'h9F;
    ip = 5'b00100;
    pulse_src(5'b00111);
    push_grant(3'd2, 8'h13);
    pulse_boundary();
    pulse_ack();
    total++;
    if (pending !== 5'b00011 || in_svc_hi !== 1'b1 || in_svc_lo !== 1'b0) begin
      bad++;
      $display("FAIL prio_ack: got pend=%b hi=%b lo=%b, required 00011/1/0",
               pending, in_svc_hi, in_svc_lo);
    end
    pulse_reti();
    pulse_boundary();  // skipped boundary after RETI
    total++;
    if (cu_if.int_req !== 1'b0) begin
      bad++;
      $display("FAIL skip_after_reti: got req=%b, required 0", cu_if.int_req);
    end
    push_grant(3'd0, 8'h03);
    pulse_boundary();
    total++;
    if (cu_if.int_req !== 1'b1) begin
      bad++;
      $display("FAIL prio_second: got req=%b, required 1", cu_if.int_req);
    end
    pulse_ack();
    total++;
    if (in_svc_lo !== 1'b1 || in_svc_hi !== 1'b0 || pending !== 5'b00010) begin
      bad++;
      $display("FAIL prio_second_ack: got pend=%b hi=%b lo=%b, required 00010/0/1",
               pending, in_svc_hi, in_svc_lo);
    end
    pulse_reti();
    pulse_boundary();
    sw_clr = 5'b11111;
    tick();
    sw_clr = '0;
    ip = '0;
  endtask

  task automatic test_nesting();
    ie = 8'h9F;
    ip = '0;
    pulse_src(5'b00001);
    push_grant(3'd0, 8'h03);
    pulse_boundary();
    pulse_ack();
    pulse_src(5'b00010);
    pulse_boundary();
    total++;
    if (cu_if.int_req !== 1'b0) begin
      bad++;
      $display("FAIL lo_blocks_lo: got req=%b, required 0", cu_if.int_req);
    end
    ip = 5'b00010;
    push_grant(3'd1, 8'h0B);
    pulse_boundary();
    pulse_ack();
    total++;
    if (in_svc_hi !== 1'b1 || in_svc_lo !== 1'b1) begin
      bad++;
      $display("FAIL nest_hi: got hi=%b lo=%b, required 1/1", in_svc_hi, in_svc_lo);
    end
    ip = 5'b01010;
    pulse_src(5'b01000);
    pulse_boundary();
    total++;
    if (cu_if.int_req !== 1'b0) begin
      bad++;
      $display("FAIL hi_blocks_all: got req=%b, required 0", cu_if.int_req);
    end
    pulse_reti();
    total++;
    if (in_svc_hi !== 1'b0 || in_svc_lo !== 1'b1) begin
      bad++;
      $display("FAIL reti_clears_hi: got hi=%b lo=%b, required 0/1", in_svc_hi, in_svc_lo);
    end
    pulse_boundary();  // skipped
    push_grant(3'd3, 8'h1B);
    pulse_boundary();
    pulse_ack();
    pulse_reti();
    pulse_reti();
    total++;
    if (in_svc_hi !== 1'b0 || in_svc_lo !== 1'b0) begin
      bad++;
      $display("FAIL nest_unwind: got hi=%b lo=%b, required 0/0", in_svc_hi, in_svc_lo);
    end
    pulse_boundary();
    ip = '0;
  endtask

  task automatic test_ser_swclr();
    ie = 8'h9F;
    ip = '0;
    pulse_src(5'b10000);
    push_grant(3'd4, 8'h23);
    pulse_boundary();
    pulse_ack();
    total++;
    if (pending !== 5'b10000) begin
      bad++;
      $display("FAIL ser_no_autoclr: got pend=%b, required 10000", pending);
    end
    sw_clr = 5'b10000;
    tick();
    sw_clr = '0;
    total++;
    if (pending !== 5'b00000) begin
      bad++;
      $display("FAIL ser_swclr: got pend=%b, required 00000", pending);
    end
    pulse_reti();
    pulse_boundary();
    pulse_src(5'b00001);
    push_grant(3'd0, 8'h03);
    pulse_boundary();
    src_req = 5'b00001;
    cu_if.int_ack = 1'b1;
    tick();
    src_req = '0;
    cu_if.int_ack = 1'b0;
    total++;
    if (pending !== 5'b00001 || in_svc_lo !== 1'b1) begin
      bad++;
      $display("FAIL set_beats_ack: got pend=%b lo=%b, required 00001/1", pending, in_svc_lo);
    end
    sw_clr = 5'b11111;
    cu_if.reti_done = 1'b1;
    tick();
    sw_clr = '0;
    cu_if.reti_done = 1'b0;
    pulse_boundary();
    total++;
    if (pending !== 5'b00000 || in_svc_lo !== 1'b0 || cu_if.int_req !== 1'b0) begin
      bad++;
      $display("FAIL ser_cleanup: got pend=%b lo=%b req=%b, required 00000/0/0",
               pending, in_svc_lo, cu_if.int_req);
    end
  endtask

  task automatic test_freeze_reset();
    ie = 8'h81;
    ip = '0;
    pulse_src(5'b00001);
    push_grant(3'd0, 8'h03);
    pulse_boundary();
    ie = 8'h01;
    pulse_src(5'b00010);
    pulse_boundary();  // ignored while a request is outstanding
    tick();
    total++;
    if (cu_if.int_req !== 1'b1 || cu_if.int_vector !== 8'h03 || cu_if.int_src !== 3'd0) begin
      bad++;
      $display("FAIL frozen_req: got req=%b vec=%h src=%0d, required 1/03/0",
               cu_if.int_req, cu_if.int_vector, cu_if.int_src);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (cu_if.int_req !== 1'b0 || cu_if.int_vector !== 8'h00 || cu_if.int_src !== 3'd0 ||
        pending !== 5'b0 || in_svc_hi !== 1'b0 || in_svc_lo !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got req=%b vec=%h src=%0d pend=%b hi=%b lo=%b, required all 0",
               cu_if.int_req, cu_if.int_vector, cu_if.int_src, pending, in_svc_hi, in_svc_lo);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    src_req         = '0;
    sw_clr          = '0;
    ie              = '0;
    ip              = '0;
    cu_if.boundary  = 1'b0;
    cu_if.reti_done = 1'b0;
    cu_if.int_ack   = 1'b0;
    #2;
    test_reset();
    test_basic_grant();
    test_priority_skip();
    test_nesting();
    test_ser_swclr();
    test_freeze_reset();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d outstanding grants, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_sched_ctrl.md
Name: int_sched_ctrl

Overview:
- 8051-style interrupt scheduler sitting beside control_unit; decides at instruction boundaries whether to divert the fetch sequence to an interrupt vector.
- Latches five request sources (INT0, T0, INT1, T1, SER), applies IE/IP enable and priority rules, and tracks two-level in-service nesting.
- Issues a held request/vector to control_unit (hardware ACALL) and releases nesting on RETI.

Parameters:
- NSRC, 5, number of interrupt sources; index 0 has the highest natural priority.
- VEC_BASE, 8'h03, vector address of source 0.
- VEC_STRIDE, 8'h08, vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE.
- AUTO_CLR, 5'b01111, per-source: 1 = pending cleared by hardware on ack (SER = 0, cleared only by software).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- src_req  in  NSRC  request strobes/levels, sampled every clock.
- sw_clr  in  NSRC  software clear of pending flags.
- ie  in  8  IE SFR; bit7 = EA, bits[NSRC-1:0] = per-source enables.
- ip  in  NSRC  IP SFR; 1 = high priority.
- boundary  in  1  one-cycle pulse from control_unit at end of s_execute.
- reti_done  in  1  one-cycle pulse when RETI has executed.
- int_ack  in  1  control_unit accepted the request (vector push started).
- int_req  out  1  interrupt request to control_unit.
- int_vector  out  8  target address, valid while int_req = 1.
- int_src  out  3  index of the granted source, valid while int_req = 1.
- pending  out  NSRC  pending flags, readable as TCON/SCON bits.
- in_svc_hi  out  1  high-priority ISR active.
- in_svc_lo  out  1  low-priority ISR active.

Behaviour:
- Reset values: int_req = 0, int_vector = 8'h00, int_src = 0, pending = 0, in_svc_hi = 0, in_svc_lo = 0, skip_next = 0. FSM = S_IDLE.
- Pending update each clock: pending[i] <= src_req[i] | (pending[i] & ~sw_clr[i] & ~(ack_clr[i])).
  - ack_clr[i] = int_ack & (int_src == i) & AUTO_CLR[i].
  - Simultaneous set and clear: set wins; no request is lost.
- Eligibility uses registered pending only. A src_req arriving in the boundary cycle is not eligible until the next boundary.
- eligible[i] = pending[i] & ie[i] & ie[7].
- Selection:
  - If any eligible source has ip = 1, choose the lowest such index.
  - Otherwise choose the lowest eligible index.
- Blocking rules, evaluated at the boundary:
  - in_svc_hi = 1 blocks everything.
  - in_svc_lo = 1 admits high-priority selections only.
  - skip_next = 1 blocks this one boundary, then skip_next clears.
- FSM:
  - S_IDLE: on boundary with an unblocked selection, register int_src and int_vector, set int_req = 1, go to S_REQ. Latency: int_req rises on the clock edge ending the boundary cycle. No boundary, or blocked: stay.
  - S_REQ: int_req, int_src and int_vector are held frozen; selection is committed. Later IE/IP/pending changes do not withdraw or alter the request. On int_ack: int_req <= 0, set in_svc_hi if ip[int_src] was 1 at grant time (registered), else in_svc_lo; go to S_IDLE.
  - boundary while in S_REQ is ignored.
  - Illegal state: go to S_IDLE and drop int_req.
- RETI handling, on reti_done:
  - Clear in_svc_hi if set, otherwise clear in_svc_lo.
  - Set skip_next = 1, guaranteeing one instruction after RETI before the next interrupt.
  - If reti_done and int_ack occur in the same cycle, apply the RETI clear first, then the ack set.
- reti_done with no level in service: no nesting change; skip_next is still set.
- int_ack while in S_IDLE: ignored, no state change.
- Reset asserted mid-request: int_req drops asynchronously; the pending request is discarded.
- Vector arithmetic is 8-bit and wraps modulo 256; defaults give 03, 0B, 13, 1B, 23.

Test Plan:
- ie = 8'h81, src_req[0] pulse, boundary at cycle 5 → int_req = 1 at cycle 6, int_vector = 8'h03, int_src = 0; int_ack → pending[0] = 0, in_svc_lo = 1.
- ie = 8'h9F, ip = 5'b00100, pending = 5'b00111 → grant src 2 (vector 8'h13) before src 0; after ack and reti_done, the next boundary is skipped and the following boundary grants src 0.
- in_svc_lo = 1, low-priority src 1 pending → no int_req; set ip[1] = 1 → granted at the next boundary (vector 8'h0B), in_svc_hi = 1; high-priority src 3 pending → blocked until reti_done.
- SER (src 4) granted and acked → pending[4] stays 1; sw_clr[4] pulse → pending[4] = 0; src_req[0] coincident with an ack of src 0 → pending[0] remains 1.
- int_req high, then ie[7] cleared before ack → int_req and int_vector stay unchanged until int_ack; reset asserted during S_REQ → all outputs 0 immediately, without a clock edge.
